// File: rtl/hyperbus_if.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_if
// Description : HyperBus link as seen through the ioddr pads, one 2xWIDTH
//               word per clk: chip select, DQ and RWDS in both directions.
// Revision    : 1.0  initial release
// ============================================================================
interface hyperbus_if #(
  parameter int WIDTH = 8
);
  logic               hbus_csn;
  logic [2*WIDTH-1:0] dq_in;
  logic [1:0]         rwds_in;
  logic [2*WIDTH-1:0] dq_out;
  logic               dq_oe;
  logic [1:0]         rwds_out;
  logic               rwds_oe;
  logic               active;

  // Controller side of the link
  modport master (
    output hbus_csn, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe, active
  );

  // Memory (target) side of the link
  modport slave (
    input  hbus_csn, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe, active
  );
endinterface
`default_nettype wire

// File: rtl/hyperbus_target.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_target
// Description : HyperBus responder. Decodes the 48-bit CA, signals latency on
//               RWDS, applies the initial latency, then streams read data with
//               an RWDS strobe or accepts byte-masked write data against a
//               word-addressed array plus one configuration register.
//               The CA occupies three words, so WIDTH is expected to be 8;
//               ADDR_BITS must lie in 5..19 (address taken from ca[2:0] and
//               the low bits of ca[31:16]).
// Revision    : 1.0  initial release
// ============================================================================
module hyperbus_target #(
  parameter int          WIDTH      = 8,
  parameter int          TACC_COUNT = 7,
  parameter int          LATENCY_2X = 1,
  parameter int          ADDR_BITS  = 8,
  parameter logic [15:0] CFG_RESET  = 16'h8F1F
) (
  input  logic      clk,
  input  logic      rst,
  hyperbus_if.slave bus
);

  localparam int DW    = 2 * WIDTH;
  localparam int LAT   = TACC_COUNT * ((LATENCY_2X != 0) ? 2 : 1);
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [1:0] RWDS_LAT = (LATENCY_2X != 0) ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CA      = 3'd1,
    S_LATENCY = 3'd2,
    S_READ    = 3'd3,
    S_WRITE   = 3'd4,
    S_REGWR   = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   ca_phase_q;   // 0: expecting ca[31:16], 1: ca[15:0]
  logic                   rw_q;         // 1 = read
  logic                   as_q;         // 1 = register space
  logic                   burst_q;      // 1 = linear, 0 = wrapped
  logic [ADDR_BITS-1:0]   addr_q;
  logic [CW-1:0]          count_q;
  logic                   reg_done_q;
  logic [DW-1:0]          cfg_q;
  logic [DW-1:0]          dq_out_q;
  logic                   dq_oe_q;
  logic [1:0]             rwds_out_q;
  logic                   rwds_oe_q;
  logic                   active_q;
  logic [DW-1:0]          mem_q [DEPTH];

  logic [ADDR_BITS-1:0]   addr_d;
  logic [DW-1:0]          rd_word_d;
  logic                   wr_en_d;

  // Next burst address: linear rolls over the whole array, wrapped stays
  // inside the aligned 16-word group.
  assign addr_d = burst_q ? (addr_q + ADDR_BITS'(1))
                          : {addr_q[ADDR_BITS-1:4], addr_q[3:0] + 4'd1};

  // Register space returns the config register on every word of the burst
  assign rd_word_d = as_q ? cfg_q : mem_q[addr_q];

  assign wr_en_d = !rst && (state_q == S_WRITE) && !bus.hbus_csn;

  // Array write port: each unmasked byte lands; fully masked words write nothing
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      if (!bus.rwds_in[1]) mem_q[addr_q][DW-1:WIDTH] <= bus.dq_in[DW-1:WIDTH];
      if (!bus.rwds_in[0]) mem_q[addr_q][WIDTH-1:0]  <= bus.dq_in[WIDTH-1:0];
    end
  end

  // Transaction FSM with registered pad outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ca_phase_q <= 1'b0;
      rw_q       <= 1'b0;
      as_q       <= 1'b0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      reg_done_q <= 1'b0;
      cfg_q      <= DW'(CFG_RESET);
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 2'b00;
      rwds_oe_q  <= 1'b0;
      active_q   <= 1'b0;
    end else if (state_q != S_IDLE && bus.hbus_csn) begin
      // CS# release wins over everything, including a pending data phase
      state_q    <= S_IDLE;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 2'b00;
      rwds_oe_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.hbus_csn) begin
            rw_q       <= bus.dq_in[DW-1];
            as_q       <= bus.dq_in[DW-2];
            burst_q    <= bus.dq_in[DW-3];
            ca_phase_q <= 1'b0;
            rwds_oe_q  <= 1'b1;
            rwds_out_q <= RWDS_LAT;
            active_q   <= 1'b1;
            state_q    <= S_CA;
          end
        end

        S_CA: begin
          if (!ca_phase_q) begin
            // Upper word-address bits come from ca[44:16]
            addr_q[ADDR_BITS-1:3] <= bus.dq_in[ADDR_BITS-4:0];
            ca_phase_q            <= 1'b1;
          end else begin
            addr_q[2:0] <= bus.dq_in[2:0];
            rwds_oe_q   <= 1'b0;
            rwds_out_q  <= 2'b00;
            if (as_q && !rw_q) begin
              reg_done_q <= 1'b0;
              state_q    <= S_REGWR;
            end else begin
              count_q <= CW'(LAT - 1);
              state_q <= S_LATENCY;
            end
          end
        end

        S_LATENCY: begin
          if (count_q == '0) begin
            if (rw_q) begin
              // First read word is launched on the same edge that leaves latency
              dq_out_q   <= rd_word_d;
              dq_oe_q    <= 1'b1;
              rwds_oe_q  <= 1'b1;
              rwds_out_q <= 2'b10;
              addr_q     <= addr_d;
              state_q    <= S_READ;
            end else begin
              state_q <= S_WRITE;
            end
          end else begin
            count_q <= count_q - CW'(1);
          end
        end

        S_READ: begin
          dq_out_q   <= rd_word_d;
          dq_oe_q    <= 1'b1;
          rwds_oe_q  <= 1'b1;
          rwds_out_q <= 2'b10;
          addr_q     <= addr_d;
        end

        S_WRITE: begin
          addr_q <= addr_d;
        end

        S_REGWR: begin
          if (!reg_done_q) begin
            cfg_q      <= bus.dq_in;
            reg_done_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.rwds_out = rwds_out_q;
  assign bus.rwds_oe  = rwds_oe_q;
  assign bus.active   = active_q;

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_target
// Description : Directed, table-driven bench for hyperbus_target with
//               hand-written sequences for reset, latency, abort, register
//               write and mid-burst reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hyperbus_target;

  localparam int L = 14;  // TACC_COUNT 7, 2x latency

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hyperbus_if #(.WIDTH(8)) hb ();

  hyperbus_target #(
    .WIDTH      (8),
    .TACC_COUNT (7),
    .LATENCY_2X (1),
    .ADDR_BITS  (8),
    .CFG_RESET  (16'h8F1F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          as_;
    bit          lin;
    logic [7:0]  addr;
    int          n;
    logic [63:0] data;   // word i at [16*i +: 16]; expected words for reads
    logic [7:0]  mask;   // mask i at [2*i +: 2]
  } vec_t;

  vec_t vecs [14];

  function automatic logic [63:0] w4(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [7:0] m4(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [47:0] make_ca(input bit rd, input bit as_, input bit lin,
                                          input logic [7:0] a);
    logic [47:0] c;
    c         = '0;
    c[47]     = rd;
    c[46]     = as_;
    c[45]     = lin;
    c[44:16]  = {24'd0, a[7:3]};
    c[2:0]    = a[2:0];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic csn, input logic [15:0] dq, input logic [1:0] rw);
    hb.hbus_csn = csn;
    hb.dq_in    = dq;
    hb.rwds_in  = rw;
    @(posedge clk);
    #1;
  endtask

  // Status word {active, dq_oe, rwds_oe, rwds_out}
  function automatic logic [4:0] status();
    return {hb.active, hb.dq_oe, hb.rwds_oe, hb.rwds_out};
  endfunction

  task automatic check_idle(input string name);
    check(name, {11'd0, status(), hb.dq_out}, 32'd0);
  endtask

  // Three CA words; afterwards the outputs of cycle 3 are visible
  task automatic do_ca(input bit rd, input bit as_, input bit lin, input logic [7:0] a);
    logic [47:0] c;
    c = make_ca(rd, as_, lin, a);
    tick(1'b0, c[47:32], 2'b00);
    check("ca_cyc1_status", status(), 5'b10111);
    tick(1'b0, c[31:16], 2'b00);
    check("ca_cyc2_status", status(), 5'b10111);
    tick(1'b0, c[15:0], 2'b00);
    check("ca_cyc3_status", status(), 5'b10000);
  endtask

  task automatic do_read(input string tag, input bit as_, input bit lin, input logic [7:0] a,
                         input int n, input logic [63:0] exp);
    do_ca(1'b1, as_, lin, a);
    repeat (L - 1) tick(1'b0, 16'h0000, 2'b00);
    check({tag, "_lat_quiet"}, status(), 5'b10000);
    tick(1'b0, 16'h0000, 2'b00);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_word%0d", tag, i), {16'd0, hb.dq_out}, {16'd0, exp[16*i +: 16]});
      check($sformatf("%s_strobe%0d", tag, i), status(), 5'b11110);
      if (i < n - 1) tick(1'b0, 16'h0000, 2'b00);
    end
    tick(1'b1, 16'h0000, 2'b00);
    check_idle({tag, "_end"});
  endtask

  task automatic do_write(input string tag, input bit lin, input logic [7:0] a,
                          input int n, input logic [63:0] d, input logic [7:0] m);
    do_ca(1'b0, 1'b0, lin, a);
    repeat (L) tick(1'b0, 16'h0000, 2'b00);
    check({tag, "_wr_quiet"}, status(), 5'b10000);
    for (int i = 0; i < n; i++) tick(1'b0, d[16*i +: 16], m[2*i +: 2]);
    tick(1'b1, 16'h0000, 2'b00);
    check_idle({tag, "_end"});
  endtask

  task automatic do_regwr(input logic [15:0] v);
    do_ca(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, v, 2'b11);            // rwds_in ignored for register writes
    tick(1'b0, 16'h0000, 2'b00);     // extra word must be ignored
    tick(1'b1, 16'h0000, 2'b00);
    check_idle("regwr_end");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    hb.hbus_csn = 1'b0;
    hb.dq_in    = '0;
    hb.rwds_in  = '0;

    //            rd  as  lin addr   n  data                                          mask
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h10, 2, w4(16'hA5A5, 16'h1234, 16'h0, 16'h0), m4(2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h10, 2, w4(16'hA5A5, 16'h1234, 16'h0, 16'h0), 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h20, 1, w4(16'hFFFF, 16'h0, 16'h0, 16'h0),    m4(2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h20, 1, w4(16'h1234, 16'h0, 16'h0, 16'h0),    m4(2'b10, 2'b00, 2'b00, 2'b00)};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h20, 1, w4(16'hFF34, 16'h0, 16'h0, 16'h0),    8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h1E, 2, w4(16'h1E1E, 16'h1F1F, 16'h0, 16'h0), m4(2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h1E, 4, w4(16'h1E1E, 16'h1F1F, 16'hA5A5, 16'h1234), 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h1F, 2, w4(16'h1F1F, 16'hFF34, 16'h0, 16'h0), 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h1F, 2, w4(16'h7777, 16'h8888, 16'h0, 16'h0), m4(2'b00, 2'b01, 2'b00, 2'b00)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h11, 2, w4(16'hDEAD, 16'hBEEF, 16'h0, 16'h0), m4(2'b11, 2'b00, 2'b00, 2'b00)};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h10, 3, w4(16'h88A5, 16'h1234, 16'hBEEF, 16'h0), 8'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hFF, 2, w4(16'h1111, 16'h2222, 16'h0, 16'h0), m4(2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'hFF, 2, w4(16'h1111, 16'h2222, 16'h0, 16'h0), 8'h00};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h1F, 2, w4(16'h7777, 16'h88A5, 16'h0, 16'h0), 8'h00};

    // Reset held two cycles with CS# low
    tick(1'b0, 16'hFFFF, 2'b00);
    tick(1'b0, 16'hFFFF, 2'b00);
    check_idle("reset_outputs");
    rst = 1'b0;
    tick(1'b1, 16'h0000, 2'b00);
    check_idle("reset_release");

    // Register read after reset: latency signalling and first data in cycle 3+L
    do_read("cfg_reset", 1'b1, 1'b1, 8'h00, 2, w4(16'h8F1F, 16'h8F1F, 16'h0, 16'h0));

    // Table of write/read transactions, back to back
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].rd)
        do_read($sformatf("v%0d", v), vecs[v].as_, vecs[v].lin, vecs[v].addr, vecs[v].n, vecs[v].data);
      else
        do_write($sformatf("v%0d", v), vecs[v].lin, vecs[v].addr, vecs[v].n, vecs[v].data, vecs[v].mask);
    end

    // Abort in the second read data cycle, then an immediate register write
    do_ca(1'b1, 1'b0, 1'b1, 8'h10);
    repeat (L) tick(1'b0, 16'h0000, 2'b00);
    check("abort_word0", {16'd0, hb.dq_out}, {16'd0, 16'h88A5});
    tick(1'b0, 16'h0000, 2'b00);
    check("abort_word1", {16'd0, hb.dq_out}, {16'd0, 16'h1234});
    tick(1'b1, 16'h0000, 2'b00);
    check("abort_status", status(), 5'b00000);
    do_regwr(16'h8F17);
    do_read("cfg_new", 1'b1, 1'b0, 8'h00, 2, w4(16'h8F17, 16'h8F17, 16'h0, 16'h0));

    // CS# released part-way through a write CA: nothing may be written
    tick(1'b0, make_ca(1'b0, 1'b0, 1'b1, 8'h10) >> 32, 2'b00);
    tick(1'b1, 16'h0000, 2'b00);
    check_idle("ca_abort");
    do_read("ca_abort_rd", 1'b0, 1'b1, 8'h10, 1, w4(16'h88A5, 16'h0, 16'h0, 16'h0));

    // Reset asserted mid-burst restores config and idles outputs
    do_ca(1'b1, 1'b1, 1'b1, 8'h00);
    repeat (L) tick(1'b0, 16'h0000, 2'b00);
    check("rst_mid_word0", {16'd0, hb.dq_out}, {16'd0, 16'h8F17});
    rst = 1'b1;
    tick(1'b0, 16'h0000, 2'b00);
    check_idle("rst_mid_outputs");
    rst = 1'b0;
    tick(1'b1, 16'h0000, 2'b00);
    do_read("cfg_after_rst", 1'b1, 1'b1, 8'h00, 1, w4(16'h8F1F, 16'h0, 16'h0, 16'h0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
